// File: rtl/dm_responder_if.sv
// Request/response bus between an initiator and the dm_responder data memory.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder with byte-enabled stores.
// Define DM_WAIT_STATE_EN to insert WAIT_CYCLES wait states before each access.
module dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);
    localparam int WORDS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DM_WAIT_STATE_EN
        WAIT = 2'd1,
`endif
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        lat_we_r;
    logic [31:0] lat_addr_r;
    logic [31:0] lat_wdata_r;
    logic [3:0]  lat_be_r;
    logic [31:0] mem_r [WORDS];
    logic [31:0] rdata_r;
    logic        err_r;

    logic              accept_s;
    logic              do_access_s;
    logic              use_latched_s;
    logic              acc_we_s;
    logic [31:0]       acc_addr_s;
    logic [31:0]       acc_wdata_s;
    logic [3:0]        acc_be_s;
    logic              acc_err_s;
    logic [ADDR_W-1:0] acc_idx_s;

`ifdef DM_WAIT_STATE_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
`endif

    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
    endfunction

    assign accept_s       = (state_r == IDLE) && bus.req_valid;
    assign bus.req_ready  = (state_r == IDLE) && reset;
    assign bus.resp_valid = (state_r == RESP);
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = err_r;

    // Next-state logic; decides when the single memory access happens
    always_comb begin
        state_nxt_s   = state_r;
        do_access_s   = 1'b0;
        use_latched_s = 1'b0;
`ifdef DM_WAIT_STATE_EN
        cnt_nxt_s     = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef DM_WAIT_STATE_EN
                    if (WAIT_CYCLES > 0) begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_nxt_s = RESP;
                        do_access_s = 1'b1;
                    end
`else
                    state_nxt_s = RESP;
                    do_access_s = 1'b1;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
`ifdef DM_WAIT_STATE_EN
            WAIT: begin
                if (cnt_r == '0) begin
                    state_nxt_s   = RESP;
                    do_access_s   = 1'b1;
                    use_latched_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 1'b1;
                end
            end
`endif
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Zero-wait accesses use the live request; delayed ones use the latched copy
    always_comb begin
        acc_we_s    = use_latched_s ? lat_we_r    : bus.req_we;
        acc_addr_s  = use_latched_s ? lat_addr_r  : bus.req_addr;
        acc_wdata_s = use_latched_s ? lat_wdata_r : bus.req_wdata;
        acc_be_s    = use_latched_s ? lat_be_r    : bus.req_be;
        acc_err_s   = addr_err(acc_addr_s);
        acc_idx_s   = acc_addr_s[ADDR_W+1:2];
    end

    // FSM state and request latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= 32'h0;
            lat_wdata_r <= 32'h0;
            lat_be_r    <= 4'h0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                lat_we_r    <= bus.req_we;
                lat_addr_r  <= bus.req_addr;
                lat_wdata_r <= bus.req_wdata;
                lat_be_r    <= bus.req_be;
            end
        end
    end

`ifdef DM_WAIT_STATE_EN
    // Wait-state counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

    // Memory array: cleared by reset, written only by error-free stores
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_r[i] <= 32'h0;
            end
        end else if (do_access_s && acc_we_s && !acc_err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be_s[b]) begin
                    mem_r[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Response registers are loaded on access and zeroed once consumed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= 32'h0;
            err_r   <= 1'b0;
        end else if (do_access_s) begin
            err_r   <= acc_err_s;
            rdata_r <= (acc_err_s || acc_we_s) ? 32'h0 : mem_r[acc_idx_s];
        end else if ((state_r == RESP) && bus.resp_ready) begin
            rdata_r <= 32'h0;
            err_r   <= 1'b0;
        end
    end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
- REQ-001 The module SHALL have parameter ADDR_W, default 10, giving the word-address width (2^ADDR_W words of 32 bits).
- REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted per access when DM_WAIT_STATE_EN is defined.
- REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-005 The module SHALL have port req_valid, input, 1 bit: the initiator presents a request.
- REQ-006 The module SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
- REQ-007 The module SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
- REQ-008 The module SHALL have port req_addr, input, 32 bits: byte address.
- REQ-009 The module SHALL have port req_wdata, input, 32 bits: store data.
- REQ-010 The module SHALL have port req_be, input, 4 bits: byte enables for stores; bit i covers byte i.
- REQ-011 The module SHALL have port resp_valid, output, 1 bit: a response is presented.
- REQ-012 The module SHALL have port resp_ready, input, 1 bit: the initiator consumes the response.
- REQ-013 The module SHALL have port resp_rdata, output, 32 bits: load data; 0 for stores and errors.
- REQ-014 The module SHALL have port resp_err, output, 1 bit: the address was misaligned or out of range.

Function
- REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
- REQ-016 req_ready SHALL be 1 only in IDLE.
- REQ-017 A request SHALL be accepted on a clock edge where req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_be SHALL be latched at that edge.
- REQ-018 Accept with DM_WAIT_STATE_EN defined and WAIT_CYCLES>0: go to WAIT and load the counter with WAIT_CYCLES-1.
- REQ-019 Accept otherwise: perform the access and go to RESP.
- REQ-020 In WAIT, the counter SHALL decrement each cycle; at counter 0 the access SHALL be performed and the FSM SHALL go to RESP. Load latency from accept edge to resp_valid is WAIT_CYCLES+1 edges.
- REQ-021 Access rule: error when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0; an error SHALL leave memory unchanged, set resp_err=1 and set resp_rdata=0.
- REQ-022 Store: each byte with be[i]=1 SHALL be written from wdata; be=4'b0000 SHALL write nothing and still produce a response.
- REQ-023 Load: resp_rdata SHALL be the full 32-bit word at addr[ADDR_W+1:2]; req_be SHALL be ignored.
- REQ-024 In RESP: resp_valid=1, and resp_rdata and resp_err SHALL be held stable until the edge where resp_ready=1; at that edge the FSM SHALL go to IDLE.
- REQ-025 At most one request SHALL be outstanding; a new request SHALL NOT be accepted in the same cycle a response is consumed.
- REQ-026 resp_valid SHALL be 0 in IDLE and WAIT.
- REQ-027 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
- REQ-028 Input changes while not in IDLE SHALL have no effect.

Reset
- REQ-029 While reset=0 (asynchronous, no clock required): FSM=IDLE, counter=0, latched request=0, all memory words=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0.
- REQ-030 req_ready SHALL rise to 1 after reset deasserts, with no clock edge required.
- REQ-031 Reset asserted in WAIT SHALL abort the access; a pending store SHALL NOT be written.
- REQ-032 Reset asserted in RESP SHALL discard the response.

Configuration
- REQ-033 The macro DM_WAIT_STATE_EN defined SHALL enable the WAIT state and WAIT_CYCLES wait states per access.
- REQ-034 With DM_WAIT_STATE_EN undefined, WAIT and its counter SHALL be compiled out, every access SHALL go IDLE->RESP with 1-edge latency, and WAIT_CYCLES SHALL be ignored.

Verification
- REQ-035 Store addr 0x00000010, wdata 0x12345678, be 4'hF, then load 0x10 -> resp_rdata 0x12345678, resp_err 0, and with macro defined resp_valid 3 edges after accept.
- REQ-036 Store 0x10 0xFFFFFFFF, then store 0x10 0x000000AB with be 4'b0001, then load 0x10 -> 0xFFFFFFAB.
- REQ-037 Load 0x00000006, and separately store to 0x00001000 -> resp_err 1, resp_rdata 0, and a following load of 0x0 returns 0x00000000 (memory unchanged).
- REQ-038 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid stays 1, rdata stable, req_ready stays 0 despite req_valid=1; raise resp_ready -> IDLE on the next edge.
- REQ-039 Store 0x20 0xDEADBEEF, then assert reset low during WAIT, release, load 0x20 -> 0x00000000.
- REQ-040 Rebuild with DM_WAIT_STATE_EN undefined and rerun the REQ-035 scenario -> resp_valid 1 edge after accept.
